// File: rtl/adder_share_ctrl_pkg.sv
// rtl/adder_share_ctrl_pkg.sv - shared constants and state codes for the adder-sharing front end
package adder_share_ctrl_pkg;

    localparam int NBIT = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_CALC = S_CALC,
        ST_HOLD = S_HOLD
    } state_t;

endpackage

// File: rtl/adder_share_ctrl_rr_pick.sv
// rtl/adder_share_ctrl_rr_pick.sv - combinational round-robin selector starting at ptr
module adder_share_ctrl_rr_pick
    import adder_share_ctrl_pkg::*;
(
    input  logic [NREQ-1:0] req_valid_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  g_o,
    output logic            any_valid_o
);

    int best_d;
    int d;

    // Winner is the valid requester at the smallest wrapped distance above ptr.
    always_comb begin
        best_d = NREQ;
        d      = 0;
        g_o    = '0;
        for (int i = 0; i < NREQ; i++) begin
            d = (i - int'(ptr_i) + NREQ) % NREQ;
            if (req_valid_i[i] && d < best_d) begin
                best_d = d;
                g_o    = IDW'(i);
            end
        end
    end

    assign any_valid_o = |req_valid_i;

    always_comb begin
        grant_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant_o[i] = any_valid_o && (g_o == IDW'(i));
        end
    end

endmodule

// File: rtl/ripple_adder.sv
// rtl/ripple_adder.sv - plain W-bit ripple-carry adder with carry-out
module ripple_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] s_o,
    output logic         cout_o
);

    logic [W:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | ((a_i[i] | b_i[i]) & c[i]);
    end

    assign cout_o = c[W];

endmodule

// File: rtl/adder_share_ctrl.sv
// rtl/adder_share_ctrl.sv - round-robin front end sharing one adder; ADDER_SHARE_OVF_EN adds res_ovf
module adder_share_ctrl
    import adder_share_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*NBIT-1:0] req_a,
    input  logic [NREQ*NBIT-1:0] req_b,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [NBIT-1:0]      res_s,
`ifdef ADDER_SHARE_OVF_EN
    output logic                 res_ovf,
`endif
    output logic [IDW-1:0]       res_id
);

    state_t          state_q;
    logic [IDW-1:0]  ptr_q, ptr_d, id_q, res_id_q, g;
    logic [NBIT-1:0] op_a_q, op_b_q, res_s_q, sel_a, sel_b, sum;
    logic [NREQ-1:0] grant;
    logic            any_valid, res_valid_q, msb_carry;

    adder_share_ctrl_rr_pick u_pick (
        .req_valid_i (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (grant),
        .g_o         (g),
        .any_valid_o (any_valid)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*NBIT +: NBIT];
                sel_b = req_b[i*NBIT +: NBIT];
            end
        end
    end

    assign ptr_d     = (g == IDW'(NREQ - 1)) ? '0 : g + 1'b1;
    assign req_ready = (state_q == ST_IDLE && !rst) ? grant : '0;

    ripple_adder #(.W(NBIT)) u_add (
        .a_i    (op_a_q),
        .b_i    (op_b_q),
        .s_o    (sum),
        .cout_o (msb_carry)
    );

`ifdef ADDER_SHARE_OVF_EN
    logic res_ovf_q;
    assign res_ovf = res_ovf_q;
`else
    logic carry_unused;
    assign carry_unused = msb_carry;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            id_q        <= '0;
            res_s_q     <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
`ifdef ADDER_SHARE_OVF_EN
            res_ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_valid) begin
                        op_a_q  <= sel_a;
                        op_b_q  <= sel_b;
                        id_q    <= g;
                        ptr_q   <= ptr_d;
                        state_q <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    res_s_q     <= sum;
                    res_id_q    <= id_q;
                    res_valid_q <= 1'b1;
`ifdef ADDER_SHARE_OVF_EN
                    res_ovf_q   <= msb_carry;
`endif
                    state_q     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    res_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign res_s     = res_s_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb/tb_adder_share_ctrl.sv - randomized and directed bench for adder_share_ctrl against a transaction-level model
module tb_adder_share_ctrl;
    import adder_share_ctrl_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*NBIT-1:0] req_a, req_b;
    logic                 res_valid, res_ready;
    logic [NBIT-1:0]      res_s;
    logic [IDW-1:0]       res_id;
`ifdef ADDER_SHARE_OVF_EN
    logic                 res_ovf;
`endif

    logic [NBIT-1:0] op_a [NREQ];
    logic [NBIT-1:0] op_b [NREQ];

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*NBIT +: NBIT] = op_a[i];
            req_b[i*NBIT +: NBIT] = op_b[i];
        end
    end

    adder_share_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_s     (res_s),
`ifdef ADDER_SHARE_OVF_EN
        .res_ovf   (res_ovf),
`endif
        .res_id    (res_id)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Transaction model: age counts cycles since acceptance (-1 = free).
    int m_age = -1;
    int m_ptr = 0;
    int m_s = 0, m_id = 0, m_ovf = 0, m_valid = 0;
    int p_s = 0, p_id = 0, p_ovf = 0;
    int last_accept = -1;
    int grants[$];

    function automatic int pick();
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic cycle();
        logic [NREQ-1:0] exp_ready;
        int g, total;
        #1;
        g = pick();
        exp_ready = '0;
        if (!rst && m_age < 0 && g >= 0) exp_ready[g] = 1'b1;
        check_eq("req_ready", req_ready, exp_ready);
        check_eq("res_valid", res_valid, m_valid);
        check_eq("res_s", res_s, m_s);
        check_eq("res_id", res_id, m_id);
`ifdef ADDER_SHARE_OVF_EN
        check_eq("res_ovf", res_ovf, m_ovf);
`endif
        last_accept = -1;
        if (rst) begin
            m_age = -1; m_ptr = 0; m_s = 0; m_id = 0; m_ovf = 0; m_valid = 0;
        end else if (m_age < 0) begin
            if (g >= 0) begin
                total = int'(op_a[g]) + int'(op_b[g]);
                p_s   = total % (1 << NBIT);
                p_ovf = total >> NBIT;
                p_id  = g;
                m_ptr = (g + 1) % NREQ;
                m_age = 0;
                grants.push_back(g);
                last_accept = g;
            end
        end else if (m_age == 0) begin
            m_s = p_s; m_id = p_id; m_ovf = p_ovf; m_valid = 1; m_age = 1;
        end else if (res_ready) begin
            m_valid = 0;
            m_age   = -1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cycle_drop();
        cycle();
        if (last_accept >= 0) req_valid[last_accept] = 1'b0;
    endtask

    logic [NBIT-1:0] held_s;

    initial begin
        rst = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        @(negedge clk);
        repeat (3) cycle();
        rst = 1'b0;
        repeat (20) cycle();

        // single request from requester 2
        res_ready = 1'b1;
        op_a[2] = 8'h3C; op_b[2] = 8'h05; req_valid[2] = 1'b1;
        #1 check_eq("single_ready", req_ready, 4'b0100);
        cycle_drop();
        cycle();
        #1 check_eq("single_valid", res_valid, 1);
        check_eq("single_s", res_s, 8'h41);
        check_eq("single_id", res_id, 2);
        repeat (2) cycle();

        // wrap on requester 3 (leaves ptr at 0)
        op_a[3] = 8'hFF; op_b[3] = 8'h01; req_valid[3] = 1'b1;
        cycle_drop();
        cycle();
        #1 check_eq("wrap_s", res_s, 8'h00);
`ifdef ADDER_SHARE_OVF_EN
        check_eq("wrap_ovf", res_ovf, 1);
`endif
        repeat (2) cycle();

        // fairness with all requesters continuously valid
        grants.delete();
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = NBIT'(i); op_b[i] = 8'h10; req_valid[i] = 1'b1;
        end
        repeat (15) cycle();
        req_valid = '0;
        check_eq("fair_count", grants.size(), 5);
        for (int k = 0; k < 5 && k < grants.size(); k++)
            check_eq("fair_order", grants[k], k % NREQ);
        repeat (2) cycle();

        // backpressure in HOLD
        res_ready = 1'b0;
        op_a[1] = 8'h21; op_b[1] = 8'h34; req_valid[1] = 1'b1;
        cycle_drop();
        op_a[2] = 8'h77; op_b[2] = 8'h99; req_valid[2] = 1'b1;
        cycle();
        #1 held_s = res_s;
        check_eq("bp_s_first", held_s, 8'h55);
        repeat (5) begin
            cycle();
            check_eq("bp_s_stable", res_s, held_s);
            check_eq("bp_no_ready", req_ready, 0);
        end
        res_ready = 1'b1;
        cycle();
        #1 check_eq("bp_idle_ready", req_ready, 4'b0100);
        cycle_drop();
        repeat (3) cycle();

        // reset while requester 1 is in CALC
        op_a[1] = 8'h05; op_b[1] = 8'h06; req_valid[1] = 1'b1;
        cycle();
        rst = 1'b1;
        op_a[3] = 8'h40; op_b[3] = 8'h02; req_valid[3] = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        #1 check_eq("rst_regrant", req_ready, 4'b0010);
        cycle_drop();
        cycle();
        #1 check_eq("rst_done_s", res_s, 8'h0B);
        repeat (6) cycle_drop();
        req_valid = '0;
        repeat (3) cycle();

        // randomized traffic with occasional reset
        for (int n = 0; n < 600; n++) begin
            cycle_drop();
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    op_a[i] = NBIT'($urandom);
                    op_b[i] = NBIT'($urandom);
                    req_valid[i] = 1'b1;
                end
            end
            res_ready = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 99) == 0);
        end
        rst = 1'b0;
        repeat (2) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
